rv32i_alu_imm_unit: RTL and testbench

- RV32I execute-stage datapath block. Merges the ALU (arithmetic/logic result plus branch-condition evaluation) with the immediate generator. Both are decoded from the raw 32-bit instruction.
- Sits in the E stage of the 5-stage pipelined core, fed by the operand-forwarding muxes.
- Combinational outputs serve same-cycle use. A registered copy of each output serves E/M pipeline use.

---
 rtl/rv32i_alu_imm_unit.sv | 116 +++++++++++
 tb/tb_rv32i_alu_imm_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rv32i_alu_imm_unit.sv
// rv32i_alu_imm_unit
// RV32I execute-stage datapath: immediate generator, ALU and branch
// comparator, all decoded from the raw instruction word. Every result is
// available combinationally for same-cycle use and as a registered copy
// for the E/M pipeline boundary.

module rv32i_alu_imm_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] result,
  output logic            take_b,
  output logic [XLEN-1:0] r_imm,
  output logic [XLEN-1:0] r_result,
  output logic            r_take_b
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_RIMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic [4:0] shamt;
  logic       lt_signed;
  logic       lt_unsigned;
  logic       eq;

  assign opcode      = inst[6:0];
  assign funct3      = inst[14:12];
  assign f7b5        = inst[30];
  assign shamt       = in_b[4:0];
  assign lt_signed   = $signed(in_a) < $signed(in_b);
  assign lt_unsigned = in_a < in_b;
  assign eq          = in_a == in_b;

  // Immediate decode: pick the bit layout by instruction format, sign-extend from inst[31]
  always_comb begin
    imm = '0;
    case (opcode)
      OP_LOAD, OP_RIMM, OP_JALR, OP_SYSTEM:
        imm = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {inst[31:12], 12'b0};
      OP_JAL:
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

  // ALU: funct3-selected operation for R/Rimm, plain wrapping add for every other opcode
  always_comb begin
    result = in_a + in_b;
    if (opcode == OP_R || opcode == OP_RIMM) begin
      case (funct3)
        3'b000: result = (opcode == OP_R && f7b5) ? in_a - in_b : in_a + in_b;
        3'b001: result = in_a << shamt;
        3'b010: result = {{(XLEN-1){1'b0}}, lt_signed};
        3'b011: result = {{(XLEN-1){1'b0}}, lt_unsigned};
        3'b100: result = in_a ^ in_b;
        3'b101: result = f7b5 ? XLEN'($signed(in_a) >>> shamt) : in_a >> shamt;
        3'b110: result = in_a | in_b;
        3'b111: result = in_a & in_b;
        default: result = in_a + in_b;
      endcase
    end
  end

  // Branch condition: only conditional branches can assert it, reserved funct3 never does
  always_comb begin
    take_b = 1'b0;
    if (opcode == OP_BRANCH) begin
      case (funct3)
        3'b000:  take_b = eq;
        3'b001:  take_b = !eq;
        3'b100:  take_b = lt_signed;
        3'b101:  take_b = !lt_signed;
        3'b110:  take_b = lt_unsigned;
        3'b111:  take_b = !lt_unsigned;
        default: take_b = 1'b0;
      endcase
    end
  end

  // E/M pipeline copies of the combinational results, cleared asynchronously by reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_imm    <= '0;
      r_result <= '0;
      r_take_b <= 1'b0;
    end else begin
      r_imm    <= imm;
      r_result <= result;
      r_take_b <= take_b;
    end
  end

endmodule

// File: tb/tb_rv32i_alu_imm_unit.sv
// tb_rv32i_alu_imm_unit
// Table-driven bench for rv32i_alu_imm_unit: each vector is checked on the
// combinational outputs, and its expected values go through a scoreboard
// queue to be compared against the registered outputs one edge later.

module tb_rv32i_alu_imm_unit;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] result;
    logic        take;
  } vec_t;

  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] result;
    logic        take;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic [31:0] inst;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] imm;
  logic [31:0] result;
  logic        take_b;
  logic [31:0] r_imm;
  logic [31:0] r_result;
  logic        r_take_b;

  int total = 0;
  int bad   = 0;

  vec_t vecs[$];
  exp_t sbq[$];

  rv32i_alu_imm_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .inst     (inst),
    .in_a     (in_a),
    .in_b     (in_b),
    .imm      (imm),
    .result   (result),
    .take_b   (take_b),
    .r_imm    (r_imm),
    .r_result (r_result),
    .r_take_b (r_take_b)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addVec(string n, logic [31:0] i, logic [31:0] a, logic [31:0] b,
                                 logic [31:0] im, logic [31:0] r, logic t);
    vec_t v;
    v.name = n; v.inst = i; v.a = a; v.b = b; v.imm = im; v.result = r; v.take = t;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one vector on the falling edge, check combinational outputs, queue the registered expectation
  task automatic applyStimulus(vec_t v);
    exp_t e;
    @(negedge clk);
    inst = v.inst;
    in_a = v.a;
    in_b = v.b;
    #1;
    checkOutput({v.name, ".imm"}, imm, v.imm);
    checkOutput({v.name, ".result"}, result, v.result);
    checkOutput({v.name, ".take_b"}, {31'b0, take_b}, {31'b0, v.take});
    e.imm = v.imm; e.result = v.result; e.take = v.take;
    sbq.push_back(e);
  endtask

  // After a rising edge, pop the oldest expectation and compare the registered outputs
  task automatic compareRegs(string name);
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s.scoreboard: got empty queue expected an entry", name);
    end else begin
      e = sbq.pop_front();
      checkOutput({name, ".r_imm"}, r_imm, e.imm);
      checkOutput({name, ".r_result"}, r_result, e.result);
      checkOutput({name, ".r_take_b"}, {31'b0, r_take_b}, {31'b0, e.take});
    end
  endtask

  initial begin
    exp_t e;

    //     name        inst          a             b             imm           result        take
    addVec("add",      32'h00000033, 32'd7,        32'd5,        32'h00000000, 32'd12,       1'b0);
    addVec("sub",      32'h40000033, 32'd5,        32'd7,        32'h00000000, 32'hFFFFFFFE, 1'b0);
    addVec("sub_wrap", 32'h40000033, 32'd0,        32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0);
    addVec("add_wrap", 32'h00000033, 32'hFFFFFFFF, 32'd2,        32'h00000000, 32'h00000001, 1'b0);
    addVec("rimm_nosub",32'h40010013,32'd5,        32'd7,        32'h00000400, 32'd12,       1'b0);
    addVec("sra",      32'h40005033, 32'h80000000, 32'h00000021, 32'h00000000, 32'hC0000000, 1'b0);
    addVec("srl",      32'h00005033, 32'h80000000, 32'h00000021, 32'h00000000, 32'h40000000, 1'b0);
    addVec("srai",     32'h40005013, 32'h80000000, 32'd3,        32'h00000400, 32'hF0000000, 1'b0);
    addVec("slt",      32'h00002033, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'd1,        1'b0);
    addVec("sltu",     32'h00003033, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'd0,        1'b0);
    addVec("sltu_t",   32'h00003033, 32'd1,        32'hFFFFFFFF, 32'h00000000, 32'd1,        1'b0);
    addVec("sll",      32'h00001033, 32'd1,        32'h00000024, 32'h00000000, 32'h00000010, 1'b0);
    addVec("sll_hi",   32'h00001033, 32'd1,        32'hFFFFFFE1, 32'h00000000, 32'h00000002, 1'b0);
    addVec("xor",      32'h00004033, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000000, 32'hFF00FF00, 1'b0);
    addVec("or",       32'h00006033, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000000, 32'hFFF0FFF0, 1'b0);
    addVec("and",      32'h00007033, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000000, 32'h00F000F0, 1'b0);
    addVec("addi",     32'hFFF00093, 32'd16,       32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000000F, 1'b0);
    addVec("lui",      32'h123450B7, 32'd0,        32'h12345000, 32'h12345000, 32'h12345000, 1'b0);
    addVec("auipc",    32'h12345097, 32'h00001000, 32'h12345000, 32'h12345000, 32'h12346000, 1'b0);
    addVec("beq_m4",   32'hFE000EE3, 32'd3,        32'd3,        32'hFFFFFFFC, 32'd6,        1'b1);
    addVec("beq_bimm", 32'hFE000E63, 32'd3,        32'd4,        32'hFFFFF7FC, 32'd7,        1'b0);
    addVec("jal",      32'h0080006F, 32'h00000100, 32'd4,        32'h00000008, 32'h00000104, 1'b0);
    addVec("jalr",     32'hFF8080E7, 32'h00000200, 32'd4,        32'hFFFFFFF8, 32'h00000204, 1'b0);
    addVec("sw",       32'hFE112E23, 32'h00001000, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000FFC, 1'b0);
    addVec("system",   32'h80000073, 32'd5,        32'd5,        32'hFFFFF800, 32'd10,       1'b0);
    addVec("unknown",  32'h0000007F, 32'd1,        32'd2,        32'h00000000, 32'd3,        1'b0);
    addVec("bge",      32'h00005063, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'd0,        1'b0);
    addVec("bgeu",     32'h00007063, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'd0,        1'b1);
    addVec("blt",      32'h00004063, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'd0,        1'b1);
    addVec("bltu",     32'h00006063, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'd0,        1'b0);
    addVec("bne",      32'h00001063, 32'd3,        32'd4,        32'h00000000, 32'd7,        1'b1);
    addVec("bne_eq",   32'h00001063, 32'd3,        32'd3,        32'h00000000, 32'd6,        1'b0);
    addVec("br_f3_010",32'h00002063, 32'd3,        32'd3,        32'h00000000, 32'd6,        1'b0);
    addVec("nonbr_eq", 32'h00000033, 32'd3,        32'd3,        32'h00000000, 32'd6,        1'b0);

    // Reset held with live inputs: registers stay clear, combinational path still works
    resetn = 1'b0;
    inst   = 32'h00000033;
    in_a   = 32'd1;
    in_b   = 32'd2;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.r_imm", r_imm, 32'h0);
    checkOutput("rst.r_result", r_result, 32'h0);
    checkOutput("rst.r_take_b", {31'b0, r_take_b}, 32'h0);
    checkOutput("rst.comb_result", result, 32'd3);

    // Release reset and clock once: add 1+2 lands in r_result
    @(negedge clk);
    resetn = 1'b1;
    e.imm = 32'h0; e.result = 32'd3; e.take = 1'b0;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    compareRegs("first_load");

    // Asynchronous reset between edges clears registers without a clock
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async_rst.r_imm", r_imm, 32'h0);
    checkOutput("async_rst.r_result", r_result, 32'h0);
    checkOutput("async_rst.r_take_b", {31'b0, r_take_b}, 32'h0);

    // Release mid-cycle: next rising edge reloads current inputs
    @(negedge clk);
    resetn = 1'b1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    compareRegs("reload");

    // Table vectors, each followed by a rising edge that retires it into the registers
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      compareRegs(vecs[i].name);
    end

    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
